// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared ID/EXE packet layout and buffer state encoding.
package id_exe_pkg;
  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  exe_cmd;
    logic        b;
    logic        s;
    logic        imm;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  status;
  } id_exe_pkt_t;
  localparam int ID_EXE_PKT_W = $bits(id_exe_pkt_t);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/id_exe_entry.sv
// id_exe_entry: enable-loaded packet register with async active-low clear.
module id_exe_entry
  import id_exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  id_exe_pkt_t d_i,
  output id_exe_pkt_t q_o
);
  id_exe_pkt_t pkt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_q <= '0;
    else if (en_i) pkt_q <= d_i;
  assign q_o = pkt_q;
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: 2-entry in-order ID/EXE skid buffer with flush.
// Optional saturating stall counter enabled by ID_EXE_STALL_CNT_EN.
module id_exe_reg
  import id_exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  id_exe_pkt_t in_pkt,
  output logic        out_valid,
  input  logic        out_ready,
  output id_exe_pkt_t out_pkt,
  output logic        out_los
`ifdef ID_EXE_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  state_e      state_q, state_d;
  id_exe_pkt_t head_q, tail_q, head_d;
  logic        accept, drain, head_en, tail_en;
  assign in_ready  = state_q != ST_FULL;
  assign out_valid = state_q != ST_EMPTY;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = accept ? ST_ONE : ST_EMPTY;
      ST_ONE:   state_d = (accept & ~drain) ? ST_FULL : (drain & ~accept) ? ST_EMPTY : ST_ONE;
      ST_FULL:  state_d = drain ? ST_ONE : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_EMPTY;
    else state_q <= state_d;
  // Head takes a fresh packet when it is (or is about to be) vacant, or the tail on a FULL drain.
  assign head_d  = (state_q == ST_FULL) ? tail_q : in_pkt;
  assign head_en = (accept & ((state_q == ST_EMPTY) | drain)) | ((state_q == ST_FULL) & drain);
  assign tail_en = accept & ~drain & (state_q == ST_ONE);
  id_exe_entry u_head (.clk(clk), .rst_n(rst_n), .en_i(head_en), .d_i(head_d), .q_o(head_q));
  id_exe_entry u_tail (.clk(clk), .rst_n(rst_n), .en_i(tail_en), .d_i(in_pkt), .q_o(tail_q));
  assign out_pkt = head_q;
  assign out_los = out_valid & (head_q.mem_r_en | head_q.mem_w_en);
`ifdef ID_EXE_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (out_valid & ~out_ready & ~flush & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed self-checking bench for id_exe_reg.
// Define ID_EXE_STALL_CNT_EN to also exercise the stall counter.
module tb_id_exe_reg;
  import id_exe_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_los;
  id_exe_pkt_t in_pkt, out_pkt;
`ifdef ID_EXE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0;
  int failures = 0;

  id_exe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .out_los(out_los)
`ifdef ID_EXE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic id_exe_pkt_t mk(input logic [31:0] pc, input logic r, input logic w);
    id_exe_pkt_t p;
    p = '0;
    p.pc = pc;
    p.mem_r_en = r;
    p.mem_w_en = w;
    p.wb_en = ~w;
    p.exe_cmd = pc[5:2];
    p.val_rn = ~pc;
    p.val_rm = pc ^ 32'h5A5A_0000;
    p.shift_operand = pc[11:0] ^ 12'hABC;
    p.signed_imm_24 = 24'h80_0000 | pc[23:0];
    p.dest = pc[7:4];
    p.status = 4'h9;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pkt = '0;
    #3;
    chk("rst_out_valid", 192'(out_valid), 192'(1'b0));
    chk("rst_in_ready", 192'(in_ready), 192'(1'b1));
    chk("rst_out_pkt", 192'(out_pkt), 192'(0));
    chk("rst_out_los", 192'(out_los), 192'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 192'(in_ready), 192'(1'b1));
    // single packet
    in_valid = 1'b1; in_pkt = mk(32'h10, 1'b0, 1'b0); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 192'(out_valid), 192'(1'b1));
    chk("single_pkt", 192'(out_pkt), 192'(mk(32'h10, 1'b0, 1'b0)));
    chk("single_in_ready", 192'(in_ready), 192'(1'b1));
    tick();
    chk("single_drained", 192'(out_valid), 192'(1'b0));
    // fill to FULL, third packet refused, drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_pkt = mk(32'h4, 1'b0, 1'b0);
    tick();
    in_pkt = mk(32'h8, 1'b0, 1'b0);
    tick();
    chk("full_in_ready", 192'(in_ready), 192'(1'b0));
    chk("full_head", 192'(out_pkt.pc), 192'(32'h4));
    in_pkt = mk(32'hC, 1'b0, 1'b0);
    tick();
    chk("full_refuse_rdy", 192'(in_ready), 192'(1'b0));
    chk("full_refuse_head", 192'(out_pkt.pc), 192'(32'h4));
    out_ready = 1'b1;
    tick();
    chk("order_2nd", 192'(out_pkt), 192'(mk(32'h8, 1'b0, 1'b0)));
    chk("order_rdy", 192'(in_ready), 192'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("order_3rd", 192'(out_pkt.pc), 192'(32'hC));
    chk("order_3rd_valid", 192'(out_valid), 192'(1'b1));
    tick();
    chk("order_empty", 192'(out_valid), 192'(1'b0));
    // ONE with simultaneous accept and drain
    out_ready = 1'b0; in_valid = 1'b1; in_pkt = mk(32'h1C, 1'b0, 1'b0);
    tick();
    chk("pass_head", 192'(out_pkt.pc), 192'(32'h1C));
    in_pkt = mk(32'h20, 1'b0, 1'b0); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pass_new_head", 192'(out_pkt.pc), 192'(32'h20));
    chk("pass_in_ready", 192'(in_ready), 192'(1'b1));
    tick();
    chk("pass_empty", 192'(out_valid), 192'(1'b0));
    // flush while FULL with a packet offered
    out_ready = 1'b0; in_valid = 1'b1; in_pkt = mk(32'hA0, 1'b0, 1'b0);
    tick();
    in_pkt = mk(32'hA4, 1'b0, 1'b0);
    tick();
    chk("pre_flush_rdy", 192'(in_ready), 192'(1'b0));
    flush = 1'b1; in_pkt = mk(32'hA8, 1'b0, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", 192'(out_valid), 192'(1'b0));
    chk("flush_rdy", 192'(in_ready), 192'(1'b1));
    tick();
    chk("flush_no_ghost", 192'(out_valid), 192'(1'b0));
    // load/store detection
    out_ready = 1'b0; in_valid = 1'b1; in_pkt = mk(32'h30, 1'b1, 1'b0);
    tick();
    chk("los_load", 192'(out_los), 192'(1'b1));
    out_ready = 1'b1; in_pkt = mk(32'h34, 1'b0, 1'b0);
    tick();
    chk("los_alu", 192'(out_los), 192'(1'b0));
    in_pkt = mk(32'h38, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("los_store", 192'(out_los), 192'(1'b1));
    tick();
    chk("los_empty", 192'(out_los), 192'(1'b0));
    // reset while FULL, between edges
    out_ready = 1'b0; in_valid = 1'b1; in_pkt = mk(32'h40, 1'b1, 1'b0);
    tick();
    in_pkt = mk(32'h44, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("prereset_valid", 192'(out_valid), 192'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 192'(out_valid), 192'(1'b0));
    chk("async_rst_rdy", 192'(in_ready), 192'(1'b1));
    chk("async_rst_pkt", 192'(out_pkt), 192'(0));
    chk("async_rst_los", 192'(out_los), 192'(1'b0));
`ifdef ID_EXE_STALL_CNT_EN
    chk("async_rst_cnt", 192'(stall_cnt), 192'(16'h0));
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 192'(out_valid), 192'(1'b0));
`ifdef ID_EXE_STALL_CNT_EN
    in_valid = 1'b1; in_pkt = mk(32'h50, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("cnt_at_accept", 192'(stall_cnt), 192'(16'h0));
    repeat (5) tick();
    chk("cnt_five", 192'(stall_cnt), 192'(16'd5));
    repeat (70000) tick();
    chk("cnt_saturate", 192'(stall_cnt), 192'(16'hFFFF));
    tick();
    chk("cnt_no_wrap", 192'(stall_cnt), 192'(16'hFFFF));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
